// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register. Talks to a variable-latency
// instruction memory via req/ready, parks early returns in a one-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        PCSrc_D,
  input  logic [31:0] PCBranch_D,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] Instr_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D
);

  typedef enum logic [1:0] {S_REQ, S_BUF, S_KILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_q, kill_d;
  logic [31:0] bins_q, bins_d;
  logic [31:0] bpc4_q, bpc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        move, redir, fire, xfer;
  logic [31:0] tgt, pc_plus4, xins, xpc4;

  assign move     = !Stall_F && !Stall_D;
  assign redir    = PCSrc_D && !Stall_D;
  assign tgt      = PCBranch_D & ~32'h3;
  assign pc_plus4 = pc_q + 32'd4;

  // Request is suppressed during reset so nothing can be accepted then.
  assign Imem_Req  = !rst && (state_q != S_BUF);
  assign Imem_Addr = rst ? 32'h0 : ((state_q == S_KILL) ? kill_q : pc_q);
  assign fire      = Imem_Req && Imem_Ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    bins_d  = bins_q;
    bpc4_d  = bpc4_q;
    xfer    = 1'b0;
    xins    = 32'h0;
    xpc4    = 32'h0;
    case (state_q)
      S_REQ: begin
        if (fire) begin
          if (redir) begin
            pc_d = tgt;
          end else if (move) begin
            xfer = 1'b1;
            xins = Imem_Rdata;
            xpc4 = pc_plus4;
            pc_d = pc_plus4;
          end else begin
            bins_d  = Imem_Rdata;
            bpc4_d  = pc_plus4;
            state_d = S_BUF;
          end
        end else if (redir) begin
          kill_d  = pc_q;
          pc_d    = tgt;
          state_d = S_KILL;
        end
      end
      S_BUF: begin
        if (redir) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (move) begin
          xfer    = 1'b1;
          xins    = bins_q;
          xpc4    = bpc4_q;
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      S_KILL: begin
        // PC_F already holds the live target; only a newer redirect changes it.
        if (redir) pc_d = tgt;
        if (fire)  state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!Stall_D) begin
      if (!redir && xfer) begin
        instr_d = xins;
        pc4_d   = xpc4;
        valid_d = 1'b1;
      end else begin
        instr_d = 32'h0;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 32'h0;
      bins_q  <= 32'h0;
      bpc4_q  <= 32'h0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      bins_q  <= bins_d;
      bpc4_q  <= bpc4_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign Instr_D   = instr_q;
  assign PCPlus4_D = pc4_q;
  assign Valid_D   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory handshake is driven by hand each cycle.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall_F = 1'b0, Stall_D = 1'b0, PCSrc_D = 1'b0;
  logic [31:0] PCBranch_D = 32'h0;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ready = 1'b0;
  logic [31:0] Imem_Rdata = 32'h0;
  logic [31:0] Instr_D, PCPlus4_D;
  logic        Valid_D;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .Stall_F(Stall_F), .Stall_D(Stall_D),
    .PCSrc_D(PCSrc_D), .PCBranch_D(PCBranch_D),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ready(Imem_Ready), .Imem_Rdata(Imem_Rdata),
    .Instr_D(Instr_D), .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic sf, input logic sd, input logic src,
                     input logic [31:0] br, input logic rdy, input logic [31:0] rd);
    Stall_F = sf; Stall_D = sd; PCSrc_D = src; PCBranch_D = br;
    Imem_Ready = rdy; Imem_Rdata = rd;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'h0, Imem_Req}, {31'h0, req});
    if (req) chk({tag, ".addr"}, Imem_Addr, addr);
  endtask

  task automatic chk_d(input string tag, input logic v, input logic [31:0] pc4, input logic [31:0] ins);
    chk({tag, ".valid"}, {31'h0, Valid_D}, {31'h0, v});
    chk({tag, ".pc4"}, PCPlus4_D, pc4);
    chk({tag, ".instr"}, Instr_D, ins);
  endtask

  initial begin
    // Reset, with Ready high to show nothing is accepted.
    drv(0, 0, 0, 0, 1, 32'hBAD0_0000);
    chk_if("rst_req", 0, 0);
    tick; tick;
    chk_d("rst_d", 0, 0, 0);
    rst = 1'b0;

    // Zero-wait fetches 0x100, 0x104.
    drv(0, 0, 0, 0, 1, 32'hA000_0100);
    chk_if("zw0", 1, 32'h100);
    tick; chk_d("zw0_d", 1, 32'h104, 32'hA000_0100);
    drv(0, 0, 0, 0, 1, 32'hA000_0104);
    chk_if("zw1", 1, 32'h104);
    tick; chk_d("zw1_d", 1, 32'h108, 32'hA000_0104);

    // Full stall for 4 cycles as 0x108 returns -> skid buffer.
    drv(1, 1, 0, 0, 1, 32'hA000_0108);
    chk_if("st_rdy", 1, 32'h108);
    tick; chk_d("st0_d", 1, 32'h108, 32'hA000_0104);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0, 0, 1, 32'hBAD0_0001);
      chk_if("st_buf", 0, 0);
      tick; chk_d("st_hold", 1, 32'h108, 32'hA000_0104);
    end
    drv(0, 0, 0, 0, 0, 0);
    chk_if("rel", 0, 0);
    tick; chk_d("rel_d", 1, 32'h10C, 32'hA000_0108);

    // Latency-3 for 0x10C and 0x110: valid pattern 0,0,1.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 2; w++) begin
        drv(0, 0, 0, 0, 0, 0);
        chk_if("l3_wait", 1, 32'h10C + 32'(4 * k));
        tick; chk_d("l3_bub", 0, 0, 0);
      end
      drv(0, 0, 0, 0, 1, 32'hA000_010C + 32'(4 * k));
      chk_if("l3_rdy", 1, 32'h10C + 32'(4 * k));
      tick; chk_d("l3_d", 1, 32'h110 + 32'(4 * k), 32'hA000_010C + 32'(4 * k));
    end

    // Redirect to 0x400 while 0x114 is waiting -> KILL.
    drv(0, 0, 1, 32'h400, 0, 0);
    chk_if("kr", 1, 32'h114);
    tick; chk_d("kr_flush", 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk_if("kill_w", 1, 32'h114);
    tick; chk_d("kill_bub", 0, 0, 0);
    drv(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk_if("kill_rdy", 1, 32'h114);
    tick; chk_d("kill_drop", 0, 0, 0);
    drv(0, 0, 0, 0, 1, 32'hA000_0400);
    chk_if("tgt", 1, 32'h400);
    tick; chk_d("tgt_d", 1, 32'h404, 32'hA000_0400);

    // Ready together with redirect in REQ: no KILL.
    drv(0, 0, 1, 32'h800, 1, 32'hDEAD_0404);
    chk_if("rr", 1, 32'h404);
    tick; chk_d("rr_flush", 0, 0, 0);
    drv(0, 0, 0, 0, 1, 32'hA000_0800);
    chk_if("rr_tgt", 1, 32'h800);
    tick; chk_d("rr_d", 1, 32'h804, 32'hA000_0800);

    // Redirect while in BUF.
    drv(1, 1, 0, 0, 1, 32'hDEAD_0804);
    chk_if("bb_rdy", 1, 32'h804);
    tick; chk_d("bb_hold", 1, 32'h804, 32'hA000_0800);
    drv(0, 0, 1, 32'hC00, 0, 0);
    chk_if("bb_buf", 0, 0);
    tick; chk_d("bb_flush", 0, 0, 0);
    drv(0, 0, 0, 0, 1, 32'hA000_0C00);
    chk_if("bb_tgt", 1, 32'hC00);
    tick; chk_d("bb_d", 1, 32'hC04, 32'hA000_0C00);

    // PC wrap at top of address space.
    drv(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hDEAD_0C04);
    tick; chk_d("wr_flush", 0, 0, 0);
    drv(0, 0, 0, 0, 1, 32'h1234_5678);
    chk_if("wr_top", 1, 32'hFFFF_FFFC);
    tick; chk_d("wr_d", 1, 32'h0, 32'h1234_5678);
    drv(0, 0, 0, 0, 0, 0);
    chk_if("wr_zero", 1, 32'h0);

    // Reset mid-request.
    rst = 1'b1;
    drv(0, 0, 0, 0, 1, 32'hBAD0_0002);
    chk_if("rm_req", 0, 0);
    tick; chk_d("rm_d", 0, 0, 0);
    rst = 1'b0;
    drv(0, 0, 0, 0, 1, 32'hA000_0100);
    chk_if("rm_first", 1, 32'h100);
    tick; chk_d("rm_first_d", 1, 32'h104, 32'hA000_0100);

    // Reset with a full skid buffer.
    drv(1, 1, 0, 0, 1, 32'hA000_0104);
    tick;
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    chk_if("rb_req", 0, 0);
    tick; chk_d("rb_d", 0, 0, 0);
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    chk_if("rb_first", 1, 32'h100);
    tick; chk_d("rb_bub", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
